// File: rtl/fp_wb_queue.sv
// FP writeback queue: buffers FP results until the integer pipe frees the register-file write port.
// Latency: push edge N -> wb_en in cycle N+2 (N+1 via empty-queue bypass when FP_WB_BYPASS_EN is defined).
// Backpressure: fp_res_ready drops only when all DEPTH entries are occupied; int_wb_en stalls retirement.
module fp_wb_queue #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fp_res_valid,
    input  logic [WIDTH-1:0]         fp_res_data,
    input  logic [ADDR_W-1:0]        fp_res_rd,
    input  logic                     fp_res_err,
    output logic                     fp_res_ready,
    input  logic                     int_wb_en,
    output logic                     wb_en,
    output logic [ADDR_W-1:0]        wb_addr,
    output logic [WIDTH-1:0]         wb_data,
    output logic                     fp_err,
    input  logic [ADDR_W-1:0]        chk_addr,
    output logic                     chk_hit,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0]  data;
        logic [ADDR_W-1:0] rd;
        logic              err;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    entry_t          in_ent;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic            bypass;

    assign fp_res_ready = (count < DEPTH_C);
    assign head         = mem[rd_ptr];
    assign in_ent       = '{data: fp_res_data, rd: fp_res_rd, err: fp_res_err};
    assign pop          = (count != '0) && !int_wb_en;

`ifdef FP_WB_BYPASS_EN
    // An empty queue with a free write port lets the result skip storage entirely.
    assign bypass = fp_res_valid && (count == '0) && !int_wb_en;
`else
    assign bypass = 1'b0;
`endif

    assign push = fp_res_valid && fp_res_ready && !bypass;

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= in_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            fp_err  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            wb_en  <= 1'b0;
            fp_err <= 1'b0;
            // Errored results retire silently apart from the fp_err pulse; wb_addr/wb_data keep their last write.
            if (pop) begin
                wb_en  <= !head.err;
                fp_err <= head.err;
                if (!head.err) begin
                    wb_addr <= head.rd;
                    wb_data <= head.data;
                end
            end else if (bypass) begin
                wb_en  <= !in_ent.err;
                fp_err <= in_ent.err;
                if (!in_ent.err) begin
                    wb_addr <= in_ent.rd;
                    wb_data <= in_ent.data;
                end
            end
        end
    end

    // Walk the occupied slots from the head; errored entries never write, so they cannot hazard.
    always_comb begin
        logic [PW-1:0] idx;
        chk_hit = wb_en && (wb_addr == chk_addr);
        idx     = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if ((CW'(k) < count) && !mem[idx].err && (mem[idx].rd == chk_addr)) begin
                chk_hit = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_wb_queue.sv
// Randomised plus directed stimulus against a queue-based reference model with a decoupled scoreboard.
module tb_fp_wb_queue;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fp_res_valid = 1'b0;
    logic [WIDTH-1:0]  fp_res_data = '0;
    logic [ADDR_W-1:0] fp_res_rd = '0;
    logic              fp_res_err = 1'b0;
    logic              fp_res_ready;
    logic              int_wb_en = 1'b0;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [WIDTH-1:0]  wb_data;
    logic              fp_err;
    logic [ADDR_W-1:0] chk_addr = '0;
    logic              chk_hit;
    logic [$clog2(DEPTH):0] count;

    fp_wb_queue #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .fp_res_valid(fp_res_valid), .fp_res_data(fp_res_data), .fp_res_rd(fp_res_rd),
        .fp_res_err(fp_res_err), .fp_res_ready(fp_res_ready),
        .int_wb_en(int_wb_en),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .fp_err(fp_err),
        .chk_addr(chk_addr), .chk_hit(chk_hit), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0]  data;
        logic [ADDR_W-1:0] rd;
        logic              err;
        int                edge_n;
    } ent_t;

    ent_t              mq[$];     // results the model holds pending
    ent_t              exp_q[$];  // retirements the DUT owes us, tagged with their edge
    int                edge_n = 0;
    bit                started = 0;
    logic              m_wb_en = 0;
    logic              m_fp_err = 0;
    logic [ADDR_W-1:0] m_wb_addr = '0;
    logic [WIDTH-1:0]  m_wb_data = '0;
    int                vectors = 0;
    int                miscompares = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, got, exp);
        end
    endtask

    function automatic void retire(input ent_t e);
        ent_t t;
        t        = e;
        t.edge_n = edge_n;
        exp_q.push_back(t);
        m_wb_en  = !e.err;
        m_fp_err = e.err;
        if (!e.err) begin
            m_wb_addr = e.rd;
            m_wb_data = e.data;
        end
    endfunction

    // Reference model: a plain list of pending results; head leaves whenever the port is free.
    always @(posedge clk) begin
        ent_t in_e;
        bit   can_push;
        bit   byp;
        edge_n++;
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            m_wb_en = 0; m_fp_err = 0; m_wb_addr = '0; m_wb_data = '0;
            started = 1;
        end else begin
            in_e     = '{data: fp_res_data, rd: fp_res_rd, err: fp_res_err, edge_n: 0};
            can_push = (mq.size() < DEPTH);
            byp      = 0;
`ifdef FP_WB_BYPASS_EN
            byp = fp_res_valid && (mq.size() == 0) && !int_wb_en;
`endif
            m_wb_en  = 0;
            m_fp_err = 0;
            if (mq.size() > 0 && !int_wb_en) retire(mq.pop_front());
            else if (byp) retire(in_e);
            if (fp_res_valid && can_push && !byp) mq.push_back(in_e);
        end
    end

    // Monitor: compares away from the active edge, pops the scoreboard on every retirement.
    always @(negedge clk) begin
        ent_t e;
        bit   hit;
        if (started) begin
            hit = m_wb_en && (m_wb_addr == chk_addr);
            foreach (mq[i]) if (!mq[i].err && mq[i].rd == chk_addr) hit = 1;
            chk("count", 64'(count), 64'(mq.size()));
            chk("fp_res_ready", 64'(fp_res_ready), 64'(mq.size() < DEPTH));
            chk("chk_hit", 64'(chk_hit), 64'(hit));
            chk("wb_en", 64'(wb_en), 64'(m_wb_en));
            chk("fp_err", 64'(fp_err), 64'(m_fp_err));
            chk("wb_addr", 64'(wb_addr), 64'(m_wb_addr));
            chk("wb_data", 64'(wb_data), 64'(m_wb_data));
            if (wb_en || fp_err) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_retire", 64'({wb_en, fp_err}), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("retire_edge", 64'(edge_n), 64'(e.edge_n));
                    chk("retire_err", 64'(fp_err), 64'(e.err));
                    if (!e.err) begin
                        chk("retire_rd", 64'(wb_addr), 64'(e.rd));
                        chk("retire_data", 64'(wb_data), 64'(e.data));
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].edge_n <= edge_n) begin
                e = exp_q.pop_front();
                chk("missed_retire", 64'(0), 64'(1));
            end
        end
    end

    task automatic drive(input logic rst, input logic v, input logic [WIDTH-1:0] d,
                         input logic [ADDR_W-1:0] rd, input logic err, input logic iw,
                         input logic [ADDR_W-1:0] ca);
        @(negedge clk);
        #1;
        rst_n = rst; fp_res_valid = v; fp_res_data = d; fp_res_rd = rd;
        fp_res_err = err; int_wb_en = iw; chk_addr = ca;
    endtask

    task automatic idle(input int n, input logic iw, input logic [ADDR_W-1:0] ca);
        for (int i = 0; i < n; i++) drive(1, 0, '0, '0, 0, iw, ca);
    endtask

    initial begin
        drive(0, 0, '0, '0, 0, 0, '0);
        drive(0, 1, 32'h1111_1111, 5'd1, 0, 0, '0);
        idle(1, 0, '0);
        // single clean push
        drive(1, 1, 32'h3F80_0000, 5'd3, 0, 0, 5'd3);
        idle(3, 0, 5'd3);
        // fill while the integer pipe holds the port, then release
        for (int i = 0; i < 5; i++) drive(1, 1, 32'hA000_0000 + i, 5'(10 + i), 0, 1, 5'd11);
        idle(2, 1, 5'd14);
        idle(6, 0, 5'd12);
        // errored result
        drive(1, 1, 32'hDEAD_BEEF, 5'd7, 1, 0, 5'd7);
        idle(3, 0, 5'd7);
        // hazard check on rd=9
        drive(1, 1, 32'h4000_0000, 5'd9, 0, 1, 5'd9);
        idle(1, 1, 5'd9);
        idle(1, 1, 5'd10);
        idle(4, 0, 5'd9);
        // simultaneous push/pop at count=2 across pointer wrap
        drive(1, 1, 32'hB000_0000, 5'd20, 0, 1, '0);
        drive(1, 1, 32'hB000_0001, 5'd21, 0, 1, '0);
        for (int i = 2; i < 9; i++) drive(1, 1, 32'hB000_0000 + i, 5'(20 + i), 0, 0, 5'd22);
        idle(4, 0, '0);
        // reset with three entries pending; push during reset must be ignored
        for (int i = 0; i < 3; i++) drive(1, 1, 32'hC000_0000 + i, 5'(1 + i), 0, 1, 5'd2);
        drive(0, 1, 32'hC0FF_EE00, 5'd5, 0, 0, 5'd2);
        idle(5, 0, 5'd5);
        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 6), $urandom(),
                  5'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)));
        end
        idle(12, 0, '0);
        chk("drained_scoreboard", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
